// File: rtl/kronos_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : kronos_decode_stage
// Purpose  : RV32I decode stage with valid/ready output and optional skid entry
// Revision : 1.0
// ============================================================================
module kronos_decode_stage #(
    parameter int SKID = 1
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        flush,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_ir,
    input  logic        fetch_vld,
    output logic        fetch_rdy,
    output logic [31:0] decode_pc,
    output logic [3:0]  decode_op,
    output logic [2:0]  decode_funct3,
    output logic        decode_alt,
    output logic [4:0]  decode_rd,
    output logic [4:0]  decode_rs1,
    output logic [4:0]  decode_rs2,
    output logic [31:0] decode_imm,
    output logic        decode_we,
    output logic        decode_illegal,
    output logic        decode_vld,
    input  logic        decode_rdy
);

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        we;
        logic        illegal;
    } dec_t;

    localparam logic [3:0] c_op_op      = 4'd0;
    localparam logic [3:0] c_op_opimm   = 4'd1;
    localparam logic [3:0] c_op_lui     = 4'd2;
    localparam logic [3:0] c_op_auipc   = 4'd3;
    localparam logic [3:0] c_op_jal     = 4'd4;
    localparam logic [3:0] c_op_jalr    = 4'd5;
    localparam logic [3:0] c_op_branch  = 4'd6;
    localparam logic [3:0] c_op_load    = 4'd7;
    localparam logic [3:0] c_op_store   = 4'd8;
    localparam logic [3:0] c_op_illegal = 4'd15;

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_two   = 2'd2;

    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    logic [3:0]  w_op;
    logic [31:0] w_imm;
    logic        w_alt, w_legal, w_wcls;
    dec_t        w_dec;

    assign w_f3     = fetch_ir[14:12];
    assign w_f7     = fetch_ir[31:25];
    assign w_imm_i  = {{20{fetch_ir[31]}}, fetch_ir[31:20]};
    assign w_imm_s  = {{20{fetch_ir[31]}}, fetch_ir[31:25], fetch_ir[11:7]};
    assign w_imm_b  = {{19{fetch_ir[31]}}, fetch_ir[31], fetch_ir[7], fetch_ir[30:25], fetch_ir[11:8], 1'b0};
    assign w_imm_u  = {fetch_ir[31:12], 12'b0};
    assign w_imm_j  = {{11{fetch_ir[31]}}, fetch_ir[31], fetch_ir[19:12], fetch_ir[20], fetch_ir[30:21], 1'b0};
    assign w_imm_sh = {27'b0, fetch_ir[24:20]};

    always_comb begin
        w_op    = c_op_illegal;
        w_imm   = '0;
        w_alt   = 1'b0;
        w_legal = 1'b0;
        w_wcls  = 1'b0;
        case (fetch_ir[6:0])
            7'b0110011: begin
                w_op    = c_op_op;
                w_alt   = fetch_ir[30];
                w_wcls  = 1'b1;
                w_legal = (w_f7 == 7'b0000000) ||
                          ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            7'b0010011: begin
                w_op   = c_op_opimm;
                w_wcls = 1'b1;
                if (w_f3 == 3'b001) begin
                    w_imm   = w_imm_sh;
                    w_alt   = fetch_ir[30];
                    w_legal = (w_f7 == 7'b0000000);
                end else if (w_f3 == 3'b101) begin
                    w_imm   = w_imm_sh;
                    w_alt   = fetch_ir[30];
                    w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                end else begin
                    w_imm   = w_imm_i;
                    w_legal = 1'b1;
                end
            end
            7'b0110111: begin w_op = c_op_lui;   w_imm = w_imm_u; w_wcls = 1'b1; w_legal = 1'b1; end
            7'b0010111: begin w_op = c_op_auipc; w_imm = w_imm_u; w_wcls = 1'b1; w_legal = 1'b1; end
            7'b1101111: begin w_op = c_op_jal;   w_imm = w_imm_j; w_wcls = 1'b1; w_legal = 1'b1; end
            7'b1100111: begin
                w_op = c_op_jalr; w_imm = w_imm_i; w_wcls = 1'b1;
                w_legal = (w_f3 == 3'b000);
            end
            7'b1100011: begin
                w_op = c_op_branch; w_imm = w_imm_b;
                w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
            end
            7'b0000011: begin
                w_op = c_op_load; w_imm = w_imm_i; w_wcls = 1'b1;
                w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
            end
            7'b0100011: begin
                w_op = c_op_store; w_imm = w_imm_s;
                w_legal = (w_f3 <= 3'b010);
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Raw register/funct fields pass through even for illegal words
    always_comb begin
        w_dec        = '0;
        w_dec.pc     = fetch_pc;
        w_dec.funct3 = w_f3;
        w_dec.rd     = fetch_ir[11:7];
        w_dec.rs1    = fetch_ir[19:15];
        w_dec.rs2    = fetch_ir[24:20];
        if (w_legal) begin
            w_dec.op  = w_op;
            w_dec.alt = w_alt;
            w_dec.imm = w_imm;
            w_dec.we  = w_wcls && (fetch_ir[11:7] != 5'd0);
        end else begin
            w_dec.op      = c_op_illegal;
            w_dec.illegal = 1'b1;
        end
    end

    logic [1:0] r_state, w_next_state;
    logic       w_accept, w_load_out, w_out_from_skid;
    dec_t       r_out, w_skid_q;

    assign w_accept   = fetch_vld && fetch_rdy && !flush;
    assign decode_vld = (r_state != c_st_empty);

    always_comb begin
        w_next_state    = r_state;
        w_load_out      = 1'b0;
        w_out_from_skid = 1'b0;
        if (flush) begin
            w_next_state = c_st_empty;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_accept) begin
                        w_load_out   = 1'b1;
                        w_next_state = c_st_one;
                    end
                end
                c_st_one: begin
                    if (w_accept && decode_rdy) begin
                        w_load_out = 1'b1;
                    end else if (w_accept) begin
                        w_next_state = c_st_two;
                    end else if (decode_rdy) begin
                        w_next_state = c_st_empty;
                    end
                end
                c_st_two: begin
                    if (decode_rdy) begin
                        w_out_from_skid = 1'b1;
                        w_next_state    = c_st_one;
                    end
                end
                default: w_next_state = c_st_empty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state <= c_st_empty;
            r_out   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_out) begin
                r_out <= w_dec;
            end else if (w_out_from_skid) begin
                r_out <= w_skid_q;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            dec_t r_skid;
            logic r_fetch_rdy;
            always_ff @(posedge clk or negedge rstz) begin
                if (!rstz) begin
                    r_skid      <= '0;
                    r_fetch_rdy <= 1'b1;
                end else begin
                    if (!flush && (r_state == c_st_one) && w_accept && !decode_rdy) begin
                        r_skid <= w_dec;
                    end
                    r_fetch_rdy <= (w_next_state != c_st_two);
                end
            end
            assign w_skid_q  = r_skid;
            assign fetch_rdy = r_fetch_rdy;
        end else begin : g_noskid
            assign w_skid_q  = '0;
            assign fetch_rdy = !decode_vld || decode_rdy;
        end
    endgenerate

    assign decode_pc      = r_out.pc;
    assign decode_op      = r_out.op;
    assign decode_funct3  = r_out.funct3;
    assign decode_alt     = r_out.alt;
    assign decode_rd      = r_out.rd;
    assign decode_rs1     = r_out.rs1;
    assign decode_rs2     = r_out.rs2;
    assign decode_imm     = r_out.imm;
    assign decode_we      = r_out.we;
    assign decode_illegal = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_kronos_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_kronos_decode_stage
// Purpose  : Self-checking bench for both SKID=1 (index 0) and SKID=0 (index 1)
// Revision : 1.0
// ============================================================================
module tb_kronos_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        we;
        logic        ill;
    } rec_t;

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  op;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        we;
        logic        ill;
    } vec_t;

    logic        clk, rstz;
    logic        flush[2];
    logic [31:0] f_pc[2], f_ir[2];
    logic        f_vld[2], f_rdy[2];
    logic [31:0] d_pc[2];
    logic [3:0]  d_op[2];
    logic [2:0]  d_f3[2];
    logic        d_alt[2];
    logic [4:0]  d_rd[2], d_rs1[2], d_rs2[2];
    logic [31:0] d_imm[2];
    logic        d_we[2], d_ill[2], d_vld[2], d_rdy[2];

    int          total, bad;
    rec_t        mem[2][2];
    int          cnt[2];
    bit          acc[2];
    logic [31:0] xlog[2][16];
    int          xn[2];
    vec_t        tbl[7];

    kronos_decode_stage #(.SKID(1)) u_dut_skid (
        .clk(clk), .rstz(rstz), .flush(flush[0]),
        .fetch_pc(f_pc[0]), .fetch_ir(f_ir[0]), .fetch_vld(f_vld[0]), .fetch_rdy(f_rdy[0]),
        .decode_pc(d_pc[0]), .decode_op(d_op[0]), .decode_funct3(d_f3[0]), .decode_alt(d_alt[0]),
        .decode_rd(d_rd[0]), .decode_rs1(d_rs1[0]), .decode_rs2(d_rs2[0]), .decode_imm(d_imm[0]),
        .decode_we(d_we[0]), .decode_illegal(d_ill[0]), .decode_vld(d_vld[0]), .decode_rdy(d_rdy[0])
    );

    kronos_decode_stage #(.SKID(0)) u_dut_noskid (
        .clk(clk), .rstz(rstz), .flush(flush[1]),
        .fetch_pc(f_pc[1]), .fetch_ir(f_ir[1]), .fetch_vld(f_vld[1]), .fetch_rdy(f_rdy[1]),
        .decode_pc(d_pc[1]), .decode_op(d_op[1]), .decode_funct3(d_f3[1]), .decode_alt(d_alt[1]),
        .decode_rd(d_rd[1]), .decode_rs1(d_rs1[1]), .decode_rs2(d_rs2[1]), .decode_imm(d_imm[1]),
        .decode_we(d_we[1]), .decode_illegal(d_ill[1]), .decode_vld(d_vld[1]), .decode_rdy(d_rdy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int k, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d actual=%h required=%h at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic rec_t get_act(input int k);
        rec_t a;
        a.pc = d_pc[k]; a.op = d_op[k]; a.f3 = d_f3[k]; a.alt = d_alt[k];
        a.rd = d_rd[k]; a.rs1 = d_rs1[k]; a.rs2 = d_rs2[k]; a.imm = d_imm[k];
        a.we = d_we[k]; a.ill = d_ill[k];
        return a;
    endfunction

    // Reference decoder: immediates built by arithmetic on field values
    function automatic rec_t ref_dec(input logic [31:0] ir, input logic [31:0] pc);
        rec_t   r;
        longint v;
        bit     ok, wr;
        int     f3, f7;
        f3 = int'(ir[14:12]);
        f7 = int'(ir[31:25]);
        r = '0;
        r.pc = pc; r.f3 = ir[14:12]; r.rd = ir[11:7]; r.rs1 = ir[19:15]; r.rs2 = ir[24:20];
        ok = 1'b1; wr = 1'b1; v = 0;
        case (ir[6:0])
            7'h33: begin
                r.op = 4'd0; r.alt = ir[30];
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            end
            7'h13: begin
                r.op = 4'd1;
                if (f3 == 1 || f3 == 5) begin
                    v = longint'(ir[24:20]); r.alt = ir[30];
                    ok = (f7 == 0) || (f3 == 5 && f7 == 32);
                end else begin
                    v = longint'(ir[31:20]); if (v >= 2048) v -= 4096;
                end
            end
            7'h37: begin r.op = 4'd2; v = longint'(ir[31:12]) * 4096; end
            7'h17: begin r.op = 4'd3; v = longint'(ir[31:12]) * 4096; end
            7'h6F: begin
                r.op = 4'd4;
                v = longint'(ir[31]) * 1048576 + longint'(ir[19:12]) * 4096 +
                    longint'(ir[20]) * 2048 + longint'(ir[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            7'h67: begin
                r.op = 4'd5; ok = (f3 == 0);
                v = longint'(ir[31:20]); if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                r.op = 4'd6; wr = 1'b0; ok = (f3 != 2) && (f3 != 3);
                v = longint'(ir[31]) * 4096 + longint'(ir[7]) * 2048 +
                    longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h03: begin
                r.op = 4'd7; ok = !(f3 == 3 || f3 >= 6);
                v = longint'(ir[31:20]); if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                r.op = 4'd8; wr = 1'b0; ok = (f3 <= 2);
                v = longint'(ir[31:25]) * 32 + longint'(ir[11:7]);
                if (v >= 2048) v -= 4096;
            end
            default: ok = 1'b0;
        endcase
        r.imm = 32'(v);
        if (!ok) begin
            r.op = 4'd15; r.ill = 1'b1; r.imm = '0; r.we = 1'b0; r.alt = 1'b0;
        end else begin
            r.we = wr && (ir[11:7] != 5'd0);
        end
        return r;
    endfunction

    // Check both DUTs at the falling edge, then advance the model past the rising edge
    task automatic step();
        bit exp_rdy;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp_rdy = (k == 0) ? (cnt[k] < 2) : (cnt[k] == 0 || d_rdy[k]);
            chk("vld", k, 96'(d_vld[k]), 96'(cnt[k] > 0));
            chk("fetch_rdy", k, 96'(f_rdy[k]), 96'(exp_rdy));
            if (cnt[k] > 0) chk("data", k, 96'(get_act(k)), 96'(mem[k][0]));
            if (d_vld[k] && d_rdy[k] && xn[k] < 16) begin
                xlog[k][xn[k]] = d_pc[k];
                xn[k]++;
            end
            acc[k] = f_vld[k] && exp_rdy && !flush[k];
            if (flush[k]) begin
                cnt[k] = 0;
            end else begin
                if (cnt[k] > 0 && d_rdy[k]) begin
                    mem[k][0] = mem[k][1];
                    cnt[k]--;
                end
                if (acc[k] && cnt[k] < 2) begin
                    mem[k][cnt[k]] = ref_dec(f_ir[k], f_pc[k]);
                    cnt[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int k);
        chk("rst_vld", k, 96'(d_vld[k]), 96'(0));
        chk("rst_rdy", k, 96'(f_rdy[k]), 96'(1));
        chk("rst_data", k, 96'(get_act(k)), 96'(0));
    endtask

    function automatic logic [31:0] gen_ir();
        logic [31:0] r;
        logic [6:0]  opcs[9];
        int          sel;
        opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h37; opcs[3] = 7'h17; opcs[4] = 7'h6F;
        opcs[5] = 7'h67; opcs[6] = 7'h63; opcs[7] = 7'h03; opcs[8] = 7'h23;
        r = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 9) r[6:0] = opcs[sel];
        if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
        return r;
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            f_vld[k] = 1'b0; flush[k] = 1'b0; d_rdy[k] = 1'b1;
        end
    endtask

    task automatic stream3(input int k);
        logic [31:0] words[3];
        int idx;
        words[0] = 32'h00100093; words[1] = 32'h00200113; words[2] = 32'h00300193;
        idx = 0;
        xn[k] = 0;
        for (int c = 0; c < 10; c++) begin
            f_vld[k] = (idx < 3);
            f_ir[k]  = words[idx % 3];
            f_pc[k]  = 32'h200 + 32'(4 * idx);
            d_rdy[k] = (c >= 4);
            step();
            if (acc[k]) idx++;
            if (k == 0 && c == 1) chk("rdy_after_B", k, 96'(f_rdy[0]), 96'(0));
        end
        f_vld[k] = 1'b0; d_rdy[k] = 1'b1;
        step();
        chk("stream_count", k, 96'(xn[k]), 96'(3));
        for (int j = 0; j < 3; j++) chk("stream_order", k, 96'(xlog[k][j]), 96'(32'h200 + 32'(4 * j)));
    endtask

    initial begin
        total = 0; bad = 0;
        tbl[0] = '{32'hFFF00093, 4'd1,  1'b0, 5'd1,  5'd0, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[1] = '{32'hFE208EE3, 4'd6,  1'b0, 5'd29, 5'd1, 5'd2,  32'hFFFFFFFC, 1'b0, 1'b0};
        tbl[2] = '{32'h123452B7, 4'd2,  1'b0, 5'd5,  5'd8, 5'd3,  32'h12345000, 1'b1, 1'b0};
        tbl[3] = '{32'h0020A423, 4'd8,  1'b0, 5'd8,  5'd1, 5'd2,  32'h00000008, 1'b0, 1'b0};
        tbl[4] = '{32'h00000000, 4'd15, 1'b0, 5'd0,  5'd0, 5'd0,  32'h00000000, 1'b0, 1'b1};
        tbl[5] = '{32'h4000D013, 4'd1,  1'b1, 5'd0,  5'd1, 5'd0,  32'h00000000, 1'b0, 1'b0};
        tbl[6] = '{32'h8000D013, 4'd15, 1'b0, 5'd0,  5'd1, 5'd0,  32'h00000000, 1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; xn[k] = 0; acc[k] = 1'b0;
            f_pc[k] = '0; f_ir[k] = '0;
        end
        idle_all();
        rstz = 1'b1;
        #3 rstz = 1'b0;
        #10;
        chk_reset(0);
        chk_reset(1);
        @(posedge clk);
        #1 rstz = 1'b1;

        // Directed vectors through the SKID=1 instance, one per cycle
        for (int i = 0; i < 7; i++) begin
            f_vld[0] = 1'b1; f_ir[0] = tbl[i].ir; f_pc[0] = 32'h1000 + 32'(4 * i); d_rdy[0] = 1'b1;
            step();
            f_vld[0] = 1'b0;
            chk("vec_vld", 0, 96'(d_vld[0]), 96'(1));
            chk("vec_fields", 0,
                96'({d_op[0], d_alt[0], d_rd[0], d_rs1[0], d_rs2[0], d_imm[0], d_we[0], d_ill[0]}),
                96'({tbl[i].op, tbl[i].alt, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].we, tbl[i].ill}));
        end
        step();

        stream3(0);
        stream3(1);

        // Flush while two entries are held, with a word offered in the same cycle
        d_rdy[0] = 1'b0;
        f_vld[0] = 1'b1; f_ir[0] = 32'h00100093; f_pc[0] = 32'h300; step();
        f_ir[0] = 32'h00200113; f_pc[0] = 32'h304; step();
        f_ir[0] = 32'h00400213; f_pc[0] = 32'h308; flush[0] = 1'b1; step();
        flush[0] = 1'b0; f_vld[0] = 1'b0;
        chk("flush_vld", 0, 96'(d_vld[0]), 96'(0));
        chk("flush_rdy", 0, 96'(f_rdy[0]), 96'(1));
        xn[0] = 0; d_rdy[0] = 1'b1;
        repeat (3) step();
        chk("flush_drop", 0, 96'(xn[0]), 96'(0));

        // Asynchronous reset between edges with data held in both instances
        for (int k = 0; k < 2; k++) begin
            d_rdy[k] = 1'b0; f_vld[k] = 1'b1; f_ir[k] = 32'h00500293; f_pc[k] = 32'h400;
        end
        step();
        for (int k = 0; k < 2; k++) begin f_ir[k] = 32'h00600313; f_pc[k] = 32'h404; end
        step();
        for (int k = 0; k < 2; k++) f_vld[k] = 1'b0;
        #1 rstz = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(1);
        cnt[0] = 0; cnt[1] = 0;
        #1 rstz = 1'b1;
        for (int k = 0; k < 2; k++) begin
            d_rdy[k] = 1'b1; f_vld[k] = 1'b1; f_ir[k] = 32'h00700393; f_pc[k] = 32'h500;
        end
        step();
        for (int k = 0; k < 2; k++) begin
            f_vld[k] = 1'b0;
            chk("post_rst_vld", k, 96'(d_vld[k]), 96'(1));
            chk("post_rst_pc", k, 96'(d_pc[k]), 96'(32'h500));
        end
        step();

        // Randomized traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < 2; k++) begin
                f_vld[k] = ($urandom_range(0, 3) != 0);
                f_ir[k]  = gen_ir();
                f_pc[k]  = $urandom;
                d_rdy[k] = ($urandom_range(0, 2) != 0);
                flush[k] = ($urandom_range(0, 19) == 0);
            end
            step();
        end
        idle_all();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
